// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//   UART receiver with a configurable frame format: DATA_BITS data bits
//   (LSB first), optional even/odd parity and one or two stop bits.
//   The serial input passes through a 2-flop synchroniser. Each bit is taken
//   as the 3-sample majority around the bit centre. A start bit that is not
//   low at its centre is treated as a glitch and ignored. Parity and framing
//   problems are reported alongside the received word.
//
// Parameters
//   CLK_F        system clock frequency, Hz
//   UART_BPS     baud rate, bit/s (CLK_F/UART_BPS must be >= 8)
//   DATA_BITS    data bits per frame, 5..9
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    1 or 2
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-high
//   uart_rxd       serial line, idle high, asynchronous to clk
//   uart_data_out  last received word, held until the next uart_done
//   uart_done      1-clk pulse, frame complete; data and flags valid
//   parity_err     parity mismatch on the frame flagged by uart_done
//   frame_err      a stop bit sampled low on the frame flagged by uart_done
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int CLK_F       = 50_000_000,
  parameter int UART_BPS    = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] uart_data_out,
  output logic                 uart_done,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int BAUD_DIV = CLK_F / UART_BPS;
  localparam int CW       = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] SMP_LO  = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] SMP_MID = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] SMP_HI  = CW'(BAUD_DIV / 2 + 1);
  localparam logic [CW-1:0] CNT_END = CW'(BAUD_DIV - 1);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       ODD_PAR   = (PARITY_MODE == 2);
  localparam logic       HAS_PAR   = (PARITY_MODE != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Synchroniser and edge-detect delay; reset to the idle (high) level so
  // leaving reset never looks like a start edge.
  logic rxd_m_q;
  logic rxd_s_q;
  logic rxd_dly_q;

  state_t                 state_q;
  logic [CW-1:0]          clk_cnt_q;
  logic [3:0]             bit_cnt_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   smp0_q;
  logic                   smp1_q;
  logic                   par_bad_q;
  logic                   ferr_lat_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   done_q;
  logic                   perr_q;
  logic                   ferr_q;

  logic at_mid;
  logic at_end;
  logic maj;
  logic [CW-1:0] clk_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m_q   <= 1'b1;
      rxd_s_q   <= 1'b1;
      rxd_dly_q <= 1'b1;
    end else begin
      rxd_m_q   <= uart_rxd;
      rxd_s_q   <= rxd_m_q;
      rxd_dly_q <= rxd_s_q;
    end
  end

  // The third sample is the live synchronised value, so the vote resolves
  // in the same cycle as the last sample ("mid point").
  always_comb begin
    at_mid    = (clk_cnt_q == SMP_HI);
    at_end    = (clk_cnt_q == CNT_END);
    maj       = (smp0_q & smp1_q) | (smp0_q & rxd_s_q) | (smp1_q & rxd_s_q);
    clk_cnt_d = at_end ? '0 : clk_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      smp0_q     <= 1'b1;
      smp1_q     <= 1'b1;
      par_bad_q  <= 1'b0;
      ferr_lat_q <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      // Done and the flags are single-cycle; they clear together.
      done_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;

      if (state_q != IDLE) begin
        clk_cnt_q <= clk_cnt_d;
        if (clk_cnt_q == SMP_LO)  smp0_q <= rxd_s_q;
        if (clk_cnt_q == SMP_MID) smp1_q <= rxd_s_q;
      end

      case (state_q)
        IDLE: begin
          // Edge-triggered: a line held low cannot start a second frame.
          if (rxd_dly_q && !rxd_s_q) begin
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            par_bad_q  <= 1'b0;
            ferr_lat_q <= 1'b0;
            state_q    <= START;
          end
        end

        START: begin
          if (at_mid && maj) begin
            state_q <= IDLE;
          end else if (at_end) begin
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end

        DATA: begin
          if (at_mid) begin
            shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
          end
          if (at_end) begin
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
              state_q   <= HAS_PAR ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

        PARITY: begin
          if (at_mid) begin
            par_bad_q <= ((^shreg_q) ^ maj) != ODD_PAR;
          end
          if (at_end) begin
            bit_cnt_q <= '0;
            state_q   <= STOP;
          end
        end

        STOP: begin
          if (at_mid) begin
            if (bit_cnt_q == LAST_STOP) begin
              // Finish at the centre of the last stop bit so a start bit
              // that follows immediately still sees a falling edge in IDLE.
              data_q  <= shreg_q;
              done_q  <= 1'b1;
              perr_q  <= par_bad_q;
              ferr_q  <= ferr_lat_q | ~maj;
              state_q <= IDLE;
            end else if (!maj) begin
              ferr_lat_q <= 1'b1;
            end
          end
          if (at_end) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_data_out = data_q;
  assign uart_done     = done_q;
  assign parity_err    = perr_q;
  assign frame_err     = ferr_q;

endmodule
